// File: rtl/pkt_capture_pkg.sv
// Shared types for the packet capture tap: FSM states, descriptor record
// and the length padding helper.
package pkt_capture_pkg;

  localparam int HDR_BYTES = 16;

  typedef enum logic [1:0] {IDLE, CAPT, DROP} cap_state_t;
  typedef enum logic [1:0] {I_IDLE, I_ISSUE, I_WAIT} iss_state_t;

  typedef struct packed {
    logic [15:0] len;
    logic        error;
    logic        truncated;
    logic [31:0] sec;
    logic [31:0] nsec;
  } desc_t;

  // Round a byte length up to the next whole 32-bit word.
  function automatic logic [15:0] pad4(input logic [15:0] l);
    return (l + 16'd3) & ~16'd3;
  endfunction

endpackage

// File: rtl/pkt_capture_desc_fifo.sv
// Small synchronous FIFO holding committed packet descriptors between the
// capture side and the write-controller issue side.
module desc_fifo
  import pkt_capture_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  desc_t                    din,
  input  logic                     pop,
  output desc_t                    dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  desc_t          mem [DEPTH];
  logic [AW:0]    wr_ptr;
  logic [AW:0]    rd_ptr;
  logic           do_push;
  logic           do_pop;

  assign count   = wr_ptr - rd_ptr;
  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr[AW-1:0]];

  // Read/write pointers carry one extra wrap bit so full and empty differ.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage needs no reset; entries are only read once written.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/pkt_capture.sv
// Receive-stream tap: copies accepted packet words into the shared data FIFO,
// queues one descriptor per committed packet and hands descriptors one at a
// time to the DDR write controller, allocating records in a circular buffer.
module pkt_capture
  import pkt_capture_pkg::*;
#(
  parameter int DATA_FIFO_DEPTH = 512,
  parameter int MAX_PKT_BYTES   = 1518,
  parameter int DESC_DEPTH      = 8,
  parameter int FIFO_MARGIN     = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        capture_en,
  input  logic [31:0] buf_base,
  input  logic [31:0] buf_size,
  input  logic [31:0] rx_data,
  input  logic        rx_valid,
  input  logic        rx_sop,
  input  logic        rx_eop,
  input  logic [1:0]  rx_empty,
  input  logic        rx_error,
  output logic        rx_ready,
  output logic [31:0] fifo_data,
  output logic        fifo_wr,
  input  logic [8:0]  usedw,
  output logic        wr_ctrl,
  output logic [31:0] control,
  output logic [31:0] pkt_begin,
  output logic [31:0] pkt_end,
  output logic [31:0] write_address,
  output logic [31:0] seconds,
  output logic [31:0] nanoseconds,
  input  logic        wr_ctrl_rdy,
  input  logic [31:0] ts_seconds,
  input  logic [31:0] ts_nanoseconds,
  output logic [31:0] pkt_count,
  output logic [31:0] drop_count
);

  localparam int          CW         = $clog2(DESC_DEPTH);
  localparam int          NEED_WORDS = (MAX_PKT_BYTES + 3) / 4 + FIFO_MARGIN;
  localparam logic [15:0] MAX_LEN    = 16'(MAX_PKT_BYTES);
  localparam logic [15:0] CLAMP_LEN  = 16'((MAX_PKT_BYTES / 4) * 4);

  cap_state_t   cap_state, cap_next;
  iss_state_t   iss_state, iss_next;

  logic [15:0]  len_q, len_d, beat_bytes, len_sum;
  logic         trunc_q, trunc_d;
  logic [31:0]  sec_q, nsec_q;
  logic         wr_d, latch_ts, pkt_inc, drop_inc;
  logic [9:0]   fifo_free;
  logic         fifo_room;

  logic         push, pop, load;
  desc_t        desc_in, head;
  logic         desc_full, desc_empty;
  logic [CW:0]  desc_count;
  logic         room_after_close;

  logic [31:0]  ptr, rec_q, head_rec, issue_addr;
  logic [15:0]  head_padded;
  logic         ptr_valid;
  logic [32:0]  rec_end, ring_end;

  assign beat_bytes       = rx_eop ? (16'd4 - {14'd0, rx_empty}) : 16'd4;
  assign len_sum          = len_q + beat_bytes;
  assign fifo_free        = 10'(DATA_FIFO_DEPTH) - {1'b0, usedw};
  assign fifo_room        = (fifo_free >= 10'(NEED_WORDS));
  assign room_after_close = (desc_count < (CW+1)'(DESC_DEPTH - 1));

  desc_fifo #(.DEPTH(DESC_DEPTH)) u_desc_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .din   (desc_in),
    .pop   (pop),
    .dout  (head),
    .full  (desc_full),
    .empty (desc_empty),
    .count (desc_count)
  );

  // Capture state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cap_state <= IDLE;
    else        cap_state <= cap_next;
  end

  // Capture next-state: accept/drop at SOP, length tracking, truncation and
  // descriptor push. A SOP arriving mid-packet closes the old packet as errored;
  // if that SOP also carries EOP it would need a second push, so it is dropped.
  always_comb begin
    cap_next = cap_state;
    wr_d     = 1'b0;
    push     = 1'b0;
    desc_in  = '0;
    len_d    = len_q;
    trunc_d  = trunc_q;
    latch_ts = 1'b0;
    pkt_inc  = 1'b0;
    drop_inc = 1'b0;
    if (rx_valid) begin
      case (cap_state)
        IDLE: begin
          if (rx_sop) begin
            if (capture_en && !desc_full && fifo_room) begin
              wr_d     = 1'b1;
              latch_ts = 1'b1;
              len_d    = beat_bytes;
              trunc_d  = 1'b0;
              if (rx_eop) begin
                push    = 1'b1;
                pkt_inc = 1'b1;
                desc_in = {beat_bytes, rx_error, 1'b0, ts_seconds, ts_nanoseconds};
              end else begin
                cap_next = CAPT;
              end
            end else begin
              drop_inc = 1'b1;
              if (!rx_eop) cap_next = DROP;
            end
          end
        end
        CAPT: begin
          if (rx_sop) begin
            push    = 1'b1;
            pkt_inc = 1'b1;
            desc_in = {len_q, 1'b1, trunc_q, sec_q, nsec_q};
            if (capture_en && room_after_close && fifo_room && !rx_eop) begin
              wr_d     = 1'b1;
              latch_ts = 1'b1;
              len_d    = beat_bytes;
              trunc_d  = 1'b0;
            end else begin
              drop_inc = 1'b1;
              cap_next = rx_eop ? IDLE : DROP;
            end
          end else begin
            if (!trunc_q) begin
              if (len_sum > MAX_LEN) begin
                trunc_d = 1'b1;
                len_d   = CLAMP_LEN;
              end else begin
                wr_d  = 1'b1;
                len_d = len_sum;
              end
            end
            if (rx_eop) begin
              push     = 1'b1;
              pkt_inc  = 1'b1;
              desc_in  = {len_d, rx_error, trunc_d, sec_q, nsec_q};
              cap_next = IDLE;
            end
          end
        end
        DROP: begin
          if (rx_eop) cap_next = IDLE;
        end
        default: cap_next = IDLE;
      endcase
    end
  end

  // Capture datapath: registered FIFO write, packet length, timestamp, counters.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_ready   <= 1'b0;
      fifo_wr    <= 1'b0;
      fifo_data  <= '0;
      len_q      <= '0;
      trunc_q    <= 1'b0;
      sec_q      <= '0;
      nsec_q     <= '0;
      pkt_count  <= '0;
      drop_count <= '0;
    end else begin
      rx_ready <= 1'b1;
      fifo_wr  <= wr_d;
      if (wr_d) fifo_data <= rx_data;
      len_q    <= len_d;
      trunc_q  <= trunc_d;
      if (latch_ts) begin
        sec_q  <= ts_seconds;
        nsec_q <= ts_nanoseconds;
      end
      if (pkt_inc) pkt_count <= pkt_count + 32'd1;
      if (drop_inc && (drop_count != '1)) drop_count <= drop_count + 32'd1;
    end
  end

  assign head_padded = pad4(head.len);
  assign head_rec    = 32'(HDR_BYTES) + {16'd0, head_padded};
  assign rec_end     = {1'b0, ptr} + {1'b0, head_rec};
  assign ring_end    = {1'b0, buf_base} + {1'b0, buf_size};
  assign issue_addr  = (rec_end > ring_end) ? buf_base : ptr;
  assign wr_ctrl     = (iss_state == I_ISSUE);
  assign pkt_begin   = '0;

  // Issue state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) iss_state <= I_IDLE;
    else        iss_state <= iss_next;
  end

  // Issue next-state: load the queue head, pulse the controller, await done.
  always_comb begin
    iss_next = iss_state;
    load     = 1'b0;
    pop      = 1'b0;
    case (iss_state)
      I_IDLE: begin
        if (!desc_empty && ptr_valid) begin
          load     = 1'b1;
          iss_next = I_ISSUE;
        end
      end
      I_ISSUE: iss_next = I_WAIT;
      I_WAIT: begin
        if (wr_ctrl_rdy) begin
          pop      = 1'b1;
          iss_next = I_IDLE;
        end
      end
      default: iss_next = I_IDLE;
    endcase
  end

  // Ring pointer and descriptor output registers, held through the wait.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr           <= '0;
      ptr_valid     <= 1'b0;
      rec_q         <= '0;
      write_address <= '0;
      pkt_end       <= '0;
      control       <= '0;
      seconds       <= '0;
      nanoseconds   <= '0;
    end else if (!ptr_valid) begin
      ptr       <= buf_base;
      ptr_valid <= 1'b1;
    end else if (load) begin
      ptr           <= issue_addr;
      rec_q         <= head_rec;
      write_address <= issue_addr;
      pkt_end       <= {16'd0, head_padded};
      control       <= {30'd0, head.truncated, head.error};
      seconds       <= head.sec;
      nanoseconds   <= head.nsec;
    end else if (pop) begin
      ptr <= ptr + rec_q;
    end
  end

endmodule

// File: tb/tb_pkt_capture.sv
// Directed bench for pkt_capture: table of packets plus hand-written
// sequences for drop, wrap, queue-full, missing EOP and async reset.
`timescale 1ns/1ps
module tb_pkt_capture;

  logic        clk;
  logic        reset;
  logic        capture_en;
  logic [31:0] buf_base, buf_size;
  logic [31:0] rx_data;
  logic        rx_valid, rx_sop, rx_eop, rx_error;
  logic [1:0]  rx_empty;
  logic        rx_ready;
  logic [31:0] fifo_data;
  logic        fifo_wr;
  logic [8:0]  usedw;
  logic        wr_ctrl;
  logic [31:0] control, pkt_begin, pkt_end, write_address, seconds, nanoseconds;
  logic        wr_ctrl_rdy;
  logic [31:0] ts_seconds, ts_nanoseconds;
  logic [31:0] pkt_count, drop_count;

  int checks = 0;
  int errors = 0;
  int wr_count = 0;
  int data_err = 0;
  int iss_count = 0;
  logic [31:0] exp_q[$];
  logic [31:0] mon_word;

  typedef struct {
    int          nbytes;
    logic        err;
    logic [31:0] sec;
    logic [31:0] nsec;
    int          words;
    logic [31:0] exp_end;
    logic [31:0] exp_ctrl;
    logic [31:0] exp_addr;
  } vec_t;

  vec_t vecs[8];

  pkt_capture dut (
    .clk            (clk),
    .reset          (reset),
    .capture_en     (capture_en),
    .buf_base       (buf_base),
    .buf_size       (buf_size),
    .rx_data        (rx_data),
    .rx_valid       (rx_valid),
    .rx_sop         (rx_sop),
    .rx_eop         (rx_eop),
    .rx_empty       (rx_empty),
    .rx_error       (rx_error),
    .rx_ready       (rx_ready),
    .fifo_data      (fifo_data),
    .fifo_wr        (fifo_wr),
    .usedw          (usedw),
    .wr_ctrl        (wr_ctrl),
    .control        (control),
    .pkt_begin      (pkt_begin),
    .pkt_end        (pkt_end),
    .write_address  (write_address),
    .seconds        (seconds),
    .nanoseconds    (nanoseconds),
    .wr_ctrl_rdy    (wr_ctrl_rdy),
    .ts_seconds     (ts_seconds),
    .ts_nanoseconds (ts_nanoseconds),
    .pkt_count      (pkt_count),
    .drop_count     (drop_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observe FIFO writes and controller pulses away from the active edge.
  always @(negedge clk) begin
    if (fifo_wr) begin
      wr_count++;
      if (exp_q.size() == 0) begin
        data_err++;
      end else begin
        mon_word = exp_q.pop_front();
        if (fifo_data !== mon_word) data_err++;
      end
    end
    if (wr_ctrl) iss_count++;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rx_valid = 1'b0;
    rx_sop   = 1'b0;
    rx_eop   = 1'b0;
    rx_error = 1'b0;
    rx_empty = 2'd0;
  endtask

  task automatic apply_stimulus(input int nbytes, input logic err, input logic [31:0] sec,
                                input logic [31:0] nsec, input int keep_words, input logic [7:0] tag);
    int beats;
    logic [31:0] word;
    beats = (nbytes + 3) / 4;
    for (int b = 0; b < beats; b++) begin
      word           = {tag, 8'(b), 16'(b * 7 + 1)};
      rx_data        = word;
      rx_valid       = 1'b1;
      rx_sop         = (b == 0);
      rx_eop         = (b == beats - 1);
      rx_empty       = rx_eop ? 2'(beats * 4 - nbytes) : 2'd0;
      rx_error       = rx_eop ? err : 1'b0;
      ts_seconds     = (b == 0) ? sec : sec + 32'h100;
      ts_nanoseconds = (b == 0) ? nsec : nsec + 32'h100;
      if (b < keep_words) exp_q.push_back(word);
      tick();
    end
  endtask

  task automatic wait_issue();
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 60 && !ok; i++) begin
      if (wr_ctrl) ok = 1'b1;
      else tick();
    end
    check_output("wr_ctrl_seen", {31'd0, ok}, 32'd1);
  endtask

  task automatic issue_check(input logic wait_pulse, input logic [31:0] e_addr, input logic [31:0] e_end,
                             input logic [31:0] e_ctrl, input logic [31:0] e_sec, input logic [31:0] e_nsec);
    if (wait_pulse) wait_issue();
    check_output("write_address", write_address, e_addr);
    check_output("pkt_end", pkt_end, e_end);
    check_output("control", control, e_ctrl);
    check_output("seconds", seconds, e_sec);
    check_output("nanoseconds", nanoseconds, e_nsec);
    check_output("pkt_begin", pkt_begin, 32'd0);
    tick();
    check_output("wr_ctrl_one_cycle", {31'd0, wr_ctrl}, 32'd0);
    ts_seconds     = 32'hDEAD_BEEF;
    ts_nanoseconds = 32'hFEED_F00D;
    tick();
    check_output("seconds_held", seconds, e_sec);
    check_output("nanoseconds_held", nanoseconds, e_nsec);
    wr_ctrl_rdy = 1'b1;
    tick();
    wr_ctrl_rdy = 1'b0;
  endtask

  task automatic do_reset(input logic [31:0] base, input logic [31:0] size);
    reset    = 1'b0;
    idle();
    buf_base = base;
    buf_size = size;
    repeat (3) tick();
    reset = 1'b1;
    tick();
    exp_q.delete();
  endtask

  initial begin
    int wr_base, derr_base, iss_base;
    logic [31:0] word;

    vecs[0] = '{64,   1'b0, 32'd5,  32'd100, 16,  32'd64,   32'd0, 32'h2000};
    vecs[1] = '{61,   1'b0, 32'd6,  32'd200, 16,  32'd64,   32'd0, 32'h2050};
    vecs[2] = '{1,    1'b0, 32'd7,  32'd300, 1,   32'd4,    32'd0, 32'h20A0};
    vecs[3] = '{10,   1'b1, 32'd8,  32'd400, 3,   32'd12,   32'd1, 32'h20B4};
    vecs[4] = '{2000, 1'b0, 32'd9,  32'd500, 379, 32'd1516, 32'd2, 32'h20D0};
    vecs[5] = '{1518, 1'b0, 32'd10, 32'd600, 380, 32'd1520, 32'd0, 32'h26CC};
    vecs[6] = '{1519, 1'b0, 32'd11, 32'd700, 379, 32'd1516, 32'd2, 32'h2CCC};
    vecs[7] = '{2000, 1'b1, 32'd12, 32'd800, 379, 32'd1516, 32'd3, 32'h32C8};

    reset          = 1'b0;
    capture_en     = 1'b1;
    buf_base       = 32'h2000;
    buf_size       = 32'h10000;
    rx_data        = '0;
    usedw          = 9'd0;
    wr_ctrl_rdy    = 1'b0;
    ts_seconds     = '0;
    ts_nanoseconds = '0;
    idle();

    // Reset state
    repeat (3) tick();
    check_output("rst_fifo_wr", {31'd0, fifo_wr}, 32'd0);
    check_output("rst_wr_ctrl", {31'd0, wr_ctrl}, 32'd0);
    check_output("rst_rx_ready", {31'd0, rx_ready}, 32'd0);
    check_output("rst_pkt_count", pkt_count, 32'd0);
    check_output("rst_drop_count", drop_count, 32'd0);
    check_output("rst_write_address", write_address, 32'd0);
    check_output("rst_pkt_end", pkt_end, 32'd0);
    check_output("rst_seconds", seconds, 32'd0);
    reset = 1'b1;
    tick();
    check_output("rx_ready_after_reset", {31'd0, rx_ready}, 32'd1);

    // Table of packets
    for (int i = 0; i < 8; i++) begin
      exp_q.delete();
      wr_base   = wr_count;
      derr_base = data_err;
      apply_stimulus(vecs[i].nbytes, vecs[i].err, vecs[i].sec, vecs[i].nsec, vecs[i].words, 8'(i));
      idle();
      issue_check(1'b1, vecs[i].exp_addr, vecs[i].exp_end, vecs[i].exp_ctrl, vecs[i].sec, vecs[i].nsec);
      check_output("words_written", 32'(wr_count - wr_base), 32'(vecs[i].words));
      check_output("fifo_data_errors", 32'(data_err - derr_base), 32'd0);
    end
    check_output("pkt_count_table", pkt_count, 32'd8);

    // Drop on insufficient FIFO space, then boundary fill levels
    exp_q.delete();
    wr_base  = wr_count;
    iss_base = iss_count;
    usedw = 9'd500;
    apply_stimulus(64, 1'b0, 32'd1, 32'd1, 0, 8'hD0);
    idle();
    repeat (10) tick();
    check_output("drop_no_writes", 32'(wr_count - wr_base), 32'd0);
    check_output("drop_no_issue", 32'(iss_count - iss_base), 32'd0);
    check_output("drop_count_1", drop_count, 32'd1);
    check_output("pkt_count_after_drop", pkt_count, 32'd8);
    usedw = 9'd129;
    apply_stimulus(8, 1'b0, 32'd2, 32'd2, 0, 8'hD1);
    idle();
    tick();
    check_output("drop_count_usedw129", drop_count, 32'd2);
    usedw = 9'd128;
    exp_q.delete();
    wr_base = wr_count;
    apply_stimulus(8, 1'b0, 32'd20, 32'd21, 2, 8'hD2);
    idle();
    issue_check(1'b1, 32'h38C4, 32'd8, 32'd0, 32'd20, 32'd21);
    check_output("usedw128_words", 32'(wr_count - wr_base), 32'd2);
    check_output("pkt_count_usedw128", pkt_count, 32'd9);
    usedw      = 9'd0;
    capture_en = 1'b0;
    apply_stimulus(8, 1'b0, 32'd3, 32'd3, 0, 8'hD3);
    idle();
    tick();
    check_output("drop_count_disabled", drop_count, 32'd3);
    capture_en = 1'b1;

    // Ring wrap with 1500-byte packets
    do_reset(32'h1000, 32'h800);
    wr_ctrl_rdy = 1'b1;
    tick();
    wr_ctrl_rdy = 1'b0;
    apply_stimulus(1500, 1'b0, 32'd50, 32'd51, 375, 8'hE0);
    idle();
    issue_check(1'b1, 32'h1000, 32'd1500, 32'd0, 32'd50, 32'd51);
    apply_stimulus(1500, 1'b0, 32'd52, 32'd53, 375, 8'hE1);
    idle();
    issue_check(1'b1, 32'h1000, 32'd1500, 32'd0, 32'd52, 32'd53);

    // Nine back-to-back packets with the controller stalled
    do_reset(32'h1000, 32'h10000);
    wr_base  = wr_count;
    iss_base = iss_count;
    for (int i = 0; i < 9; i++)
      apply_stimulus(8, 1'b0, 32'(30 + i), 32'(1000 + i), (i < 8) ? 2 : 0, 8'(8'h40 + i));
    idle();
    tick();
    check_output("qfull_drop_count", drop_count, 32'd1);
    check_output("qfull_pkt_count", pkt_count, 32'd8);
    check_output("qfull_single_issue", 32'(iss_count - iss_base), 32'd1);
    check_output("qfull_words", 32'(wr_count - wr_base), 32'd16);
    for (int i = 0; i < 8; i++)
      issue_check(i != 0, 32'h1000 + 32'(24 * i), 32'd8, 32'd0, 32'(30 + i), 32'(1000 + i));
    iss_base = iss_count;
    repeat (10) tick();
    check_output("qfull_no_extra_issue", 32'(iss_count - iss_base), 32'd0);

    // Missing EOP: a new SOP closes the open packet as errored
    exp_q.delete();
    wr_base   = wr_count;
    derr_base = data_err;
    for (int b = 0; b < 3; b++) begin
      word           = {8'h77, 8'(b), 16'h1234};
      rx_data        = word;
      rx_valid       = 1'b1;
      rx_sop         = (b == 0);
      rx_eop         = 1'b0;
      ts_seconds     = (b == 0) ? 32'd40 : 32'd99;
      ts_nanoseconds = (b == 0) ? 32'd400 : 32'd999;
      exp_q.push_back(word);
      tick();
    end
    apply_stimulus(8, 1'b0, 32'd41, 32'd410, 2, 8'h78);
    idle();
    issue_check(1'b1, 32'h10C0, 32'd12, 32'd1, 32'd40, 32'd400);
    issue_check(1'b1, 32'h10DC, 32'd8, 32'd0, 32'd41, 32'd410);
    check_output("noeop_words", 32'(wr_count - wr_base), 32'd5);
    check_output("noeop_data_errors", 32'(data_err - derr_base), 32'd0);
    check_output("noeop_pkt_count", pkt_count, 32'd10);

    // Asynchronous reset in the middle of a packet
    rx_data  = 32'hCAFE_0001;
    rx_valid = 1'b1;
    rx_sop   = 1'b1;
    rx_eop   = 1'b0;
    tick();
    rx_sop  = 1'b0;
    rx_data = 32'hCAFE_0002;
    tick();
    reset = 1'b0;
    #2;
    check_output("async_fifo_wr", {31'd0, fifo_wr}, 32'd0);
    check_output("async_pkt_count", pkt_count, 32'd0);
    check_output("async_rx_ready", {31'd0, rx_ready}, 32'd0);
    check_output("async_write_address", write_address, 32'd0);
    idle();
    tick();
    reset = 1'b1;
    tick();
    exp_q.delete();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pkt_capture.md
Name: pkt_capture

Overview:
- Upstream feeder for the DDR write controller.
- Taps the MAC receive Avalon-ST stream and writes packet words into the shared 32-bit data FIFO.
- Latches a timestamp at start-of-packet and queues one descriptor per committed packet (length, flags, timestamp).
- Issues descriptors one at a time to the write controller, allocating records in a circular DDR buffer; record = 16-byte header + padded payload.

Parameters:
- DATA_FIFO_DEPTH, 512, words in the shared data FIFO (usedw is 9 bits).
- MAX_PKT_BYTES, 1518, payload bytes beyond which a packet is truncated.
- DESC_DEPTH, 8, descriptor queue entries (power of 2).
- FIFO_MARGIN, 4, extra free words required at SOP to cover usedw latency.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous active-low reset
- capture_en  in  1  capture enable, sampled only at SOP
- buf_base  in  32  ring base byte address, 4-byte aligned
- buf_size  in  32  ring size in bytes, multiple of 4, >= 16+MAX_PKT_BYTES+3
- rx_data  in  32  stream data, first byte in [31:24]
- rx_valid  in  1  stream valid
- rx_sop  in  1  start of packet
- rx_eop  in  1  end of packet
- rx_empty  in  2  unused bytes in EOP word
- rx_error  in  1  MAC error flag, valid at EOP
- rx_ready  out  1  always 1 after reset; the tap never back-pressures
- fifo_data  out  32  data FIFO write data
- fifo_wr  out  1  data FIFO write strobe
- usedw  in  9  data FIFO fill level
- wr_ctrl  out  1  one-cycle start pulse to the write controller
- control  out  32  bit0 rx_error, bit1 truncated, others 0
- pkt_begin  out  32  always 0
- pkt_end  out  32  payload byte length rounded up to a multiple of 4
- write_address  out  32  record DDR byte address
- seconds  out  32  descriptor timestamp seconds, held stable until wr_ctrl_rdy
- nanoseconds  out  32  descriptor timestamp nanoseconds, held stable until wr_ctrl_rdy
- wr_ctrl_rdy  in  1  one-cycle completion pulse from the write controller
- ts_seconds  in  32  free-running time-of-day seconds
- ts_nanoseconds  in  32  free-running time-of-day nanoseconds
- pkt_count  out  32  committed packets, wraps at 2^32
- drop_count  out  32  dropped packets, saturating

Behaviour:
Reset values:
- All outputs 0.
- Write address pointer = buf_base, sampled on the first cycle after reset release.
- Capture FSM in IDLE, issue FSM in I_IDLE, descriptor queue empty.

Capture FSM (IDLE, CAPT, DROP), advances on rx_valid beats:
- IDLE, beat with rx_sop:
  - If capture_en, descriptor queue not full, and DATA_FIFO_DEPTH-usedw >= ceil(MAX_PKT_BYTES/4)+FIFO_MARGIN: latch ts_seconds/ts_nanoseconds, write the word to the FIFO, len := bytes in beat, go CAPT.
  - Otherwise go DROP and increment drop_count.
- A beat carrying both sop and eop is a single-word packet and completes in the same cycle.
- Beats without sop in IDLE are ignored.
- CAPT:
  - Each beat adds 4 bytes (4-rx_empty at EOP) to len.
  - fifo_wr = 1, fifo_data = rx_data, registered; fifo_wr occurs exactly 1 cycle after the accepted beat.
  - Once len would exceed MAX_PKT_BYTES: stop FIFO writes, set truncated, clamp len to MAX_PKT_BYTES rounded down to a multiple of 4.
  - EOP: push descriptor {len, error, truncated, ts}, increment pkt_count, go IDLE.
- DROP: no FIFO writes; return to IDLE on EOP.
- rx_sop in CAPT (missing EOP): close the current packet as if at EOP with the error flag set, then treat the beat as a new SOP in the same cycle.
- Length arithmetic: 16-bit; padded = (len+3) & ~3.

Issue FSM (I_IDLE, I_ISSUE, I_WAIT):
- I_IDLE, queue not empty:
  - rec = 16 + padded.
  - If ptr + rec > buf_base + buf_size, ptr := buf_base (wrap).
  - Drive write_address = ptr, pkt_end = padded, control, seconds, nanoseconds from the queue head; go I_ISSUE.
- I_ISSUE: wr_ctrl = 1 for exactly one cycle; go I_WAIT.
- I_WAIT: hold all descriptor outputs. On wr_ctrl_rdy: ptr += rec, pop queue, go I_IDLE.
- Minimum spacing between wr_ctrl pulses: 2 cycles after wr_ctrl_rdy.
- wr_ctrl_rdy outside I_WAIT is ignored.
- A queue push and pop in the same cycle are both honoured.
- Descriptors may be pushed while the issue FSM is busy; order is strictly FIFO.

Other rules:
- Asynchronous reset mid-packet or mid-issue: everything returns to reset values immediately. The data FIFO and write controller share the same reset.

Decomposition:
- Package pkt_capture_pkg: capture and issue state enums, HDR_BYTES=16, descriptor struct {len[15:0], error, truncated, sec[31:0], nsec[31:0]}.
- Sub-module desc_fifo: synchronous FIFO of descriptor structs, DESC_DEPTH entries, full/empty flags, same clk/reset.

Test Plan:
- 64-byte packet (16 beats, rx_empty=0) with ts_seconds=5, ts_nanoseconds=100 at SOP → 16 fifo_wr, pkt_end=64, write_address=buf_base, seconds=5 held until wr_ctrl_rdy; next record at buf_base+80.
- 61-byte packet (rx_empty=3 at EOP) → 16 words written, pkt_end=64.
- buf_base=0x1000, buf_size=0x800; sequence of 1500-byte packets → second record at 0x1000 after wrap (0x1000+1516+1516 > 0x1800).
- usedw=500 at SOP → packet dropped, no fifo_wr, drop_count=1, pkt_count unchanged.
- 2000-byte packet → 379 words written, pkt_end=1516, control=2.
- 9 back-to-back packets while wr_ctrl_rdy is withheld → 9th dropped (queue full); first 8 issued in order as rdy pulses arrive.
